// File: rtl/robot_pkg.sv
// Shared types for the pipe-cleaning robot: controller states, plus orientation
// and map-cell encodings used by map models and benches.
package robot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECIDE = 3'd1,
        ST_REMOVE = 3'd2,
        ST_TURN_R = 3'd3,
        ST_DONE   = 3'd4,
        ST_STUCK  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ORI_NORTH = 2'b00,
        ORI_SOUTH = 2'b01,
        ORI_EAST  = 2'b10,
        ORI_WEST  = 2'b11
    } orient_e;

    typedef enum logic [2:0] {
        CELL_FREE    = 3'd0,
        CELL_WALL    = 3'd1,
        CELL_BARRIER = 3'd2,
        CELL_TARGET  = 3'd7
    } cell_e;

    // A right turn is one left turn from DECIDE followed by this many more.
    localparam logic [1:0] TURN_R_EXTRA = 2'd2;

endpackage

// File: rtl/pipe_robot_ctrl_if.sv
// Sensor/actuator bundle between the environment (master) and the controller (slave).
interface pipe_robot_ctrl_if #(
    parameter int CNT_W = 9
);
    logic             run;
    logic             head;
    logic             left;
    logic             under;
    logic             barrier;
    logic             front;
    logic             turn;
    logic             remove;
    logic             done;
    logic             stuck;
    logic [CNT_W-1:0] moves;

    modport master (
        output run, head, left, under, barrier,
        input  front, turn, remove, done, stuck, moves
    );

    modport slave (
        input  run, head, left, under, barrier,
        output front, turn, remove, done, stuck, moves
    );
endinterface

// File: rtl/pipe_robot_ctrl.sv
// Left-hand wall-follower controller: one registered action per clock, with
// trash removal, right-turn macro, pause, move budget and stall watchdog.
module pipe_robot_ctrl
    import robot_pkg::*;
#(
    parameter int REMOVE_CYCLES = 3,
    parameter int CNT_W         = 9,
    parameter int MAX_MOVES     = 511,
    parameter int STALL_LIMIT   = 8
) (
    input  logic             clock,
    input  logic             reset,
    pipe_robot_ctrl_if.slave bus
);

    localparam int REM_W   = (REMOVE_CYCLES > 1) ? $clog2(REMOVE_CYCLES) : 1;
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    localparam logic [REM_W-1:0]   REM_INIT  = REM_W'(REMOVE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   MOVES_MAX = CNT_W'(MAX_MOVES);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

    state_e             state_q;
    logic [REM_W-1:0]   rem_cnt_q;
    logic [1:0]         tr_cnt_q;
    logic [STALL_W-1:0] stall_cnt_q;
    logic               just_turned_q;
    logic [CNT_W-1:0]   moves_q;
    logic               front_q;
    logic               turn_q;
    logic               remove_q;
    logic               done_q;
    logic               stuck_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            rem_cnt_q     <= '0;
            tr_cnt_q      <= '0;
            stall_cnt_q   <= '0;
            just_turned_q <= 1'b0;
            moves_q       <= '0;
            front_q       <= 1'b0;
            turn_q        <= 1'b0;
            remove_q      <= 1'b0;
            done_q        <= 1'b0;
            stuck_q       <= 1'b0;
        end else begin
            front_q  <= 1'b0;
            turn_q   <= 1'b0;
            remove_q <= 1'b0;
            // With run low every piece of state simply holds.
            if (bus.run) begin
                case (state_q)
                    ST_IDLE, ST_DECIDE: begin
                        if (bus.under || (moves_q == MOVES_MAX)) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else if (stall_cnt_q == STALL_MAX) begin
                            state_q <= ST_STUCK;
                            stuck_q <= 1'b1;
                        end else if (bus.barrier) begin
                            remove_q    <= 1'b1;
                            stall_cnt_q <= stall_cnt_q + 1'b1;
                            rem_cnt_q   <= REM_INIT;
                            state_q     <= (REMOVE_CYCLES > 1) ? ST_REMOVE : ST_DECIDE;
                        end else if (!bus.left && !just_turned_q) begin
                            turn_q        <= 1'b1;
                            just_turned_q <= 1'b1;
                            stall_cnt_q   <= stall_cnt_q + 1'b1;
                            state_q       <= ST_DECIDE;
                        end else if (!bus.head) begin
                            front_q       <= 1'b1;
                            just_turned_q <= 1'b0;
                            stall_cnt_q   <= '0;
                            moves_q       <= moves_q + 1'b1;
                            state_q       <= ST_DECIDE;
                        end else begin
                            turn_q      <= 1'b1;
                            stall_cnt_q <= stall_cnt_q + 1'b1;
                            tr_cnt_q    <= TURN_R_EXTRA;
                            state_q     <= ST_TURN_R;
                        end
                    end
                    ST_REMOVE: begin
                        if (stall_cnt_q == STALL_MAX) begin
                            state_q <= ST_STUCK;
                            stuck_q <= 1'b1;
                        end else begin
                            remove_q    <= 1'b1;
                            stall_cnt_q <= stall_cnt_q + 1'b1;
                            rem_cnt_q   <= rem_cnt_q - 1'b1;
                            if (rem_cnt_q == REM_W'(1)) begin
                                state_q <= ST_DECIDE;
                            end
                        end
                    end
                    ST_TURN_R: begin
                        if (stall_cnt_q == STALL_MAX) begin
                            state_q <= ST_STUCK;
                            stuck_q <= 1'b1;
                        end else begin
                            turn_q      <= 1'b1;
                            stall_cnt_q <= stall_cnt_q + 1'b1;
                            tr_cnt_q    <= tr_cnt_q - 1'b1;
                            if (tr_cnt_q == 2'd1) begin
                                state_q       <= ST_DECIDE;
                                just_turned_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    assign bus.front  = front_q;
    assign bus.turn   = turn_q;
    assign bus.remove = remove_q;
    assign bus.done   = done_q;
    assign bus.stuck  = stuck_q;
    assign bus.moves  = moves_q;

endmodule

// File: tb/tb_pipe_robot_ctrl.sv
// Directed bench: dut0 uses default parameters, dut1 uses REMOVE_CYCLES=5 and
// MAX_MOVES=4. Inputs change and outputs are sampled on the falling edge.
module tb_pipe_robot_ctrl;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    pipe_robot_ctrl_if #(.CNT_W(9)) bus0 ();
    pipe_robot_ctrl_if #(.CNT_W(9)) bus1 ();

    pipe_robot_ctrl #(
        .REMOVE_CYCLES(3), .CNT_W(9), .MAX_MOVES(511), .STALL_LIMIT(8)
    ) dut0 (
        .clock (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    pipe_robot_ctrl #(
        .REMOVE_CYCLES(5), .CNT_W(9), .MAX_MOVES(4), .STALL_LIMIT(8)
    ) dut1 (
        .clock (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Action vectors are {front, turn, remove}.
    task automatic set0(input logic r, input logic h, input logic l, input logic u, input logic b);
        bus0.run = r; bus0.head = h; bus0.left = l; bus0.under = u; bus0.barrier = b;
    endtask

    task automatic set1(input logic r, input logic h, input logic l, input logic u, input logic b);
        bus1.run = r; bus1.head = h; bus1.left = l; bus1.under = u; bus1.barrier = b;
    endtask

    function automatic logic [31:0] act0();
        return {29'd0, bus0.front, bus0.turn, bus0.remove};
    endfunction

    function automatic logic [31:0] act1();
        return {29'd0, bus1.front, bus1.turn, bus1.remove};
    endfunction

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        chk("reset_act0", act0(), 32'b000);
        chk("reset_done0", {31'd0, bus0.done}, 32'd0);
        chk("reset_stuck0", {31'd0, bus0.stuck}, 32'd0);
        chk("reset_moves0", {23'd0, bus0.moves}, 32'd0);
        chk("reset_act1", act1(), 32'b000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Idle without run
        step();
        chk("idle_norun_act", act0(), 32'b000);
        $display("idle without run: act=%03b", act0());

        // Straight corridor
        set0(1, 0, 1, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("corridor_act", act0(), 32'b100);
            chk("corridor_moves", {23'd0, bus0.moves}, 32'(i));
            $display("corridor %0d: act=%03b moves=%0d", i, act0(), bus0.moves);
        end
        chk("corridor_stuck", {31'd0, bus0.stuck}, 32'd0);

        // Barrier removal, REMOVE_CYCLES=3
        set0(1, 0, 1, 0, 1);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("remove3_act", act0(), 32'b001);
            $display("remove3 %0d: act=%03b", i, act0());
        end
        set0(1, 0, 1, 0, 0);
        step();
        chk("after_remove3_act", act0(), 32'b100);
        chk("after_remove3_moves", {23'd0, bus0.moves}, 32'd6);
        $display("after remove3: act=%03b moves=%0d", act0(), bus0.moves);

        // Dead end: right turn of three left turns
        set0(1, 1, 1, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("deadend_act", act0(), 32'b010);
            $display("dead end %0d: act=%03b", i, act0());
        end
        set0(1, 0, 1, 0, 0);
        step();
        chk("deadend_exit_act", act0(), 32'b100);
        chk("deadend_exit_moves", {23'd0, bus0.moves}, 32'd7);
        $display("dead end exit: act=%03b moves=%0d", act0(), bus0.moves);

        // Open area: turn/front alternation
        set0(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("open_act", act0(), (i % 2 == 0) ? 32'b010 : 32'b100);
            $display("open %0d: act=%03b", i, act0());
        end
        chk("open_moves", {23'd0, bus0.moves}, 32'd9);

        // Pause during the second removal cycle
        set0(1, 0, 1, 0, 1);
        step();
        chk("pause_rem1", act0(), 32'b001);
        step();
        chk("pause_rem2", act0(), 32'b001);
        set0(0, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("paused_act", act0(), 32'b000);
            $display("paused %0d: act=%03b", i, act0());
        end
        set0(1, 0, 1, 0, 1);
        step();
        chk("resume_rem3", act0(), 32'b001);
        set0(1, 0, 1, 0, 0);
        step();
        chk("resume_after_act", act0(), 32'b100);
        chk("resume_after_moves", {23'd0, bus0.moves}, 32'd10);
        $display("resume: act=%03b moves=%0d", act0(), bus0.moves);

        // under and barrier together -> DONE
        set0(1, 0, 1, 1, 1);
        step();
        chk("under_bar_act", act0(), 32'b000);
        chk("under_bar_done", {31'd0, bus0.done}, 32'd1);
        chk("under_bar_stuck", {31'd0, bus0.stuck}, 32'd0);
        step();
        chk("done_hold_act", act0(), 32'b000);
        chk("done_hold_done", {31'd0, bus0.done}, 32'd1);
        chk("done_hold_moves", {23'd0, bus0.moves}, 32'd10);
        $display("done: done=%0b moves=%0d", bus0.done, bus0.moves);

        reset = 1'b0;
        #1;
        chk("reset2_done0", {31'd0, bus0.done}, 32'd0);
        chk("reset2_moves0", {23'd0, bus0.moves}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Endless barrier -> stall watchdog trips after 8 removes
        set0(1, 0, 1, 0, 1);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("stall_rem_act", act0(), 32'b001);
        end
        step();
        chk("stall_trip_act", act0(), 32'b000);
        chk("stall_trip_stuck", {31'd0, bus0.stuck}, 32'd1);
        chk("stall_trip_done", {31'd0, bus0.done}, 32'd0);
        set0(1, 0, 1, 1, 0);
        step();
        chk("stuck_hold_stuck", {31'd0, bus0.stuck}, 32'd1);
        chk("stuck_hold_done", {31'd0, bus0.done}, 32'd0);
        chk("stuck_hold_act", act0(), 32'b000);
        $display("stall: stuck=%0b done=%0b", bus0.stuck, bus0.done);
        set0(0, 0, 0, 0, 0);

        // dut1: REMOVE_CYCLES=5 then right turn, stall limit meets under
        set1(1, 1, 1, 0, 1);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("remove5_act", act1(), 32'b001);
            $display("remove5 %0d: act=%03b", i, act1());
        end
        set1(1, 1, 1, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("turn_r1_act", act1(), 32'b010);
        end
        set1(1, 0, 1, 1, 0);
        step();
        chk("under_vs_stall_act", act1(), 32'b000);
        chk("under_vs_stall_done", {31'd0, bus1.done}, 32'd1);
        chk("under_vs_stall_stuck", {31'd0, bus1.stuck}, 32'd0);
        $display("under vs stall: done=%0b stuck=%0b", bus1.done, bus1.stuck);

        reset = 1'b0;
        #1;
        chk("reset3_done1", {31'd0, bus1.done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Move budget of 4, budget hit while barrier present
        set1(1, 0, 1, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("budget_act", act1(), 32'b100);
            chk("budget_moves", {23'd0, bus1.moves}, 32'(i));
            $display("budget %0d: act=%03b moves=%0d", i, act1(), bus1.moves);
        end
        set1(1, 0, 1, 0, 1);
        step();
        chk("budget_done_act", act1(), 32'b000);
        chk("budget_done", {31'd0, bus1.done}, 32'd1);
        chk("budget_moves_sat", {23'd0, bus1.moves}, 32'd4);
        step();
        chk("budget_hold_moves", {23'd0, bus1.moves}, 32'd4);
        chk("budget_hold_done", {31'd0, bus1.done}, 32'd1);

        reset = 1'b0;
        #1;
        @(negedge clk);
        reset = 1'b1;

        // Asynchronous reset in the middle of a right turn
        set1(1, 0, 1, 0, 0);
        step();
        chk("pre_tr_act", act1(), 32'b100);
        chk("pre_tr_moves", {23'd0, bus1.moves}, 32'd1);
        set1(1, 1, 1, 0, 0);
        step();
        chk("tr_a_act", act1(), 32'b010);
        step();
        chk("tr_b_act", act1(), 32'b010);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_act", act1(), 32'b000);
        chk("async_rst_moves", {23'd0, bus1.moves}, 32'd0);
        chk("async_rst_done", {31'd0, bus1.done}, 32'd0);
        chk("async_rst_stuck", {31'd0, bus1.stuck}, 32'd0);
        $display("async reset: act=%03b moves=%0d", act1(), bus1.moves);
        @(negedge clk);
        reset = 1'b1;
        set1(0, 0, 0, 0, 0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_robot_ctrl.md
# pipe_robot_ctrl

Second-generation pipe-cleaning robot controller: a registered left-hand wall-follower FSM that converts the four robot sensors into one action per clock (`front`, `turn` or `remove`). Compared with the first controller it adds:
- a parametrised trash-removal length;
- a right-turn macro built from consecutive left turns;
- a `run` pause input;
- a move counter with a move budget;
- a stall watchdog;
- `done`/`stuck` status.

It sits between the map/sensor model (or real sensor front-end) and the drive actuators.

## Interface
Parameters:
- `REMOVE_CYCLES`, default 3: consecutive `remove` cycles needed to clear one barrier (≥1).
- `CNT_W`, default 9: width of `moves`.
- `MAX_MOVES`, default 511: move budget (≤ 2^CNT_W − 1).
- `STALL_LIMIT`, default 8: consecutive non-`front` actions before declaring stuck (≥7).

Ports (one clock; reset is asynchronous and active-low):
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `run` in 1: 1 = execute, 0 = pause.
- `head` in 1: wall or map edge directly ahead.
- `left` in 1: wall or map edge on robot's left.
- `under` in 1: robot stands on target cell.
- `barrier` in 1: removable trash directly ahead.
- `front` out 1: move one cell forward.
- `turn` out 1: rotate 90° counter-clockwise (left).
- `remove` out 1: remove-tool active.
- `done` out 1: sticky, mission ended (target reached or budget spent).
- `stuck` out 1: sticky, watchdog tripped.
- `moves` out CNT_W: number of `front` actions issued.

## Operation
- All outputs are registered. At most one of `front`/`turn`/`remove` is high in any cycle.
- States:
  - IDLE: after reset. Moves to DECIDE on the first edge with `run`=1, taking the DECIDE decision on that same edge.
  - DECIDE: one action per edge, in priority order:
    1. `under`=1: go to DONE.
    2. `moves`==MAX_MOVES: go to DONE.
    3. `barrier`=1: `remove`=1, enter REMOVE with rem_cnt=REMOVE_CYCLES−1.
    4. `left`=0 and just_turned=0: `turn`=1, set just_turned.
    5. `head`=0: `front`=1, clear just_turned, `moves`+1.
    6. Otherwise: `turn`=1, enter TURN_R with tr_cnt=2 (right turn = 3 left turns).
  - REMOVE: `remove` held 1 each edge while rem_cnt>0 (decrementing). Sensors are ignored. Returns to DECIDE when rem_cnt reaches 0.
  - TURN_R: `turn` held 1 for 2 further edges. Sensors are ignored. Then returns to DECIDE with just_turned=0.
  - DONE / STUCK: terminal. Actions are 0. Exit only by reset.
- just_turned prevents endless spinning in open space: after a left turn the robot must advance or right-turn before turning left again.
- Stall watchdog: stall_cnt increments on every edge that registers `turn` or `remove`, and clears on `front`. When stall_cnt reaches STALL_LIMIT, go to STUCK with `stuck`=1, taking priority over the pending action.
- `run`=0 in any active state: action outputs 0 for that cycle; state, rem_cnt, tr_cnt, stall_cnt and just_turned are held. The pause resumes exactly where it left off.
- `moves` saturates at MAX_MOVES. It never wraps.

## Timing
- Sensors are sampled at the rising edge. The resulting action is visible after that edge and is valid for one cycle. The environment applies it at the next rising edge and updates sensors by the following falling edge.
- Decision latency: 1 cycle.
- Removal occupies exactly REMOVE_CYCLES consecutive `remove` cycles (plus any pause cycles). The environment clears the barrier after the last one.
- Right turn: exactly 3 consecutive `turn` cycles.
- Reset (asynchronous, mid-operation included): state=IDLE; `front`=`turn`=`remove`=`done`=`stuck`=0; `moves`=0; all internal counters and just_turned =0.
- Simultaneous events: `under` and `barrier` both 1 → DONE. Budget reached while `barrier`=1 → DONE. Stall limit hit on the same edge as `under` → DONE wins.

## Structure
- Shared package `robot_pkg`:
  - state enum (IDLE, DECIDE, REMOVE, TURN_R, DONE, STUCK);
  - orientation encoding (north=00, south=01, east=10, west=11) for benches and map models;
  - map cell codes (free=0, wall=1, barrier=2, target=7).
- Single module; no sub-module required. The stall watchdog may optionally be split out as `robot_stall_wdt` (counter + compare, parameter LIMIT).

## Test plan
- Straight corridor (left=1, head=0) for 5 cycles → five `front` pulses, `moves`=5, `stuck`=0.
- `barrier`=1 with REMOVE_CYCLES=3 → `remove` high exactly 3 cycles, then DECIDE. Repeat with REMOVE_CYCLES=5 → 5 cycles.
- Dead end (head=1, left=1, barrier=0) → 3 consecutive `turn` cycles, then `front` once head clears.
- Open area (left=0 throughout, head=0) → `turn`, `front`, `turn`, `front` alternation, never two left turns in a row.
- `run` dropped during cycle 2 of a removal, held low 4 cycles → `remove` low during pause, then exactly 1 more `remove` cycle.
- MAX_MOVES=4 → `done`=1 after 4th `front`. Separately, `reset` low mid-TURN_R → all outputs 0 immediately without a clock edge.
